// File: rtl/rebnet_ctrl_pkg.sv
// Shared types and default widths for the ReBNet layer-level control blocks.
package rebnet_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } sched_state_e;

  localparam int unsigned DEF_NUM_PE = 4;
  localparam int unsigned DEF_TILE_W = 16;
  localparam int unsigned DEF_LVL_W  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, held until released or
// until the grantee withdraws its request.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] idx;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  pick;
  logic          found;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) grant_idx = PW'(i);
    end
    ptr_nxt = PW'((int'(grant_idx) + 1) % N);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= '0;
      ptr     <= '0;
    end else if (grant_q != '0) begin
      if (rel || ((grant_q & req) == '0)) begin
        grant_q <= '0;
        ptr     <= ptr_nxt;
      end
    end else if (req != '0) begin
      grant_q <= pick;
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/pe_tile_scheduler.sv
// Layer scheduler: hands output tiles to idle PE controllers and arbitrates the
// shared weight/activation read port among them.
//
// state    | meaning
// IDLE     | waiting for a layer config, cfg_ready high
// DISPATCH | issuing tiles to the lowest-index idle PE, one per cycle
// DRAIN    | all tiles issued, waiting for every PE to report done
// DONE     | single-cycle layer_done pulse
module pe_tile_scheduler
  import rebnet_ctrl_pkg::*;
#(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int TILE_W = DEF_TILE_W,
  parameter int LVL_W  = DEF_LVL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic [LVL_W-1:0]  cfg_num_levels,
  output logic [NUM_PE-1:0] pe_start,
  output logic [TILE_W-1:0] pe_tile,
  output logic [LVL_W-1:0]  pe_levels,
  input  logic [NUM_PE-1:0] pe_done,
  input  logic [NUM_PE-1:0] pe_rd_req,
  output logic [NUM_PE-1:0] pe_rd_grant,
  input  logic              mem_rd_done,
  output logic              busy,
  output logic              layer_done
);

  sched_state_e      state, state_nxt;
  logic [TILE_W-1:0] next_tile;
  logic [TILE_W-1:0] num_tiles;
  logic [LVL_W-1:0]  num_levels;
  logic [NUM_PE-1:0] pe_busy;
  logic [NUM_PE-1:0] first_idle;
  logic [NUM_PE-1:0] start_vec;
  logic              any_idle;
  logic              cfg_xfer;

  assign cfg_xfer = cfg_valid && (state == IDLE);

  always_comb begin
    first_idle = '0;
    any_idle   = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (!any_idle && !pe_busy[i]) begin
        first_idle[i] = 1'b1;
        any_idle      = 1'b1;
      end
    end
  end

  // Busy bits are registered, so a PE freed by pe_done is only eligible next cycle.
  always_comb begin
    start_vec = '0;
    if ((state == DISPATCH) && (next_tile < num_tiles) && any_idle) begin
      start_vec = first_idle;
    end
  end

  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b0;
    busy       = 1'b1;
    layer_done = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid) begin
          state_nxt = (cfg_num_tiles == '0) ? DONE : DISPATCH;
        end
      end
      DISPATCH: begin
        if (next_tile == num_tiles) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pe_busy == '0) state_nxt = DONE;
      end
      DONE: begin
        layer_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_tile  <= '0;
      num_tiles  <= '0;
      num_levels <= '0;
      pe_busy    <= '0;
    end else begin
      if (cfg_xfer) begin
        next_tile  <= '0;
        num_tiles  <= cfg_num_tiles;
        num_levels <= (cfg_num_levels == '0) ? LVL_W'(1) : cfg_num_levels;
      end else if (start_vec != '0) begin
        next_tile <= next_tile + TILE_W'(1);
      end
      pe_busy <= (pe_busy & ~pe_done) | start_vec;
    end
  end

  assign pe_start  = start_vec;
  assign pe_tile   = (start_vec != '0) ? next_tile : '0;
  assign pe_levels = num_levels;

  rr_arbiter #(
    .N (NUM_PE)
  ) u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (pe_rd_req),
    .rel   (mem_rd_done),
    .grant (pe_rd_grant)
  );

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Directed self-checking bench for pe_tile_scheduler with scoreboard queues.
module tb_pe_tile_scheduler;

  localparam int NUM_PE = 4;
  localparam int TILE_W = 16;
  localparam int LVL_W  = 2;
  localparam int DONE_DELAY = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [TILE_W-1:0] cfg_num_tiles;
  logic [LVL_W-1:0]  cfg_num_levels;
  logic [NUM_PE-1:0] pe_start;
  logic [TILE_W-1:0] pe_tile;
  logic [LVL_W-1:0]  pe_levels;
  logic [NUM_PE-1:0] pe_done;
  logic [NUM_PE-1:0] pe_rd_req;
  logic [NUM_PE-1:0] pe_rd_grant;
  logic              mem_rd_done;
  logic              busy;
  logic              layer_done;

  logic [NUM_PE-1:0] done_auto = '0;
  logic [NUM_PE-1:0] done_man;
  logic              auto_en;
  int                cnt [NUM_PE];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [NUM_PE-1:0] pe;
    int                tile;
    int                cyc;
  } start_exp_t;

  start_exp_t        start_sb[$];
  logic [NUM_PE-1:0] grant_sb[$];

  assign pe_done = done_auto | done_man;

  pe_tile_scheduler #(
    .NUM_PE (NUM_PE),
    .TILE_W (TILE_W),
    .LVL_W  (LVL_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_num_tiles  (cfg_num_tiles),
    .cfg_num_levels (cfg_num_levels),
    .pe_start       (pe_start),
    .pe_tile        (pe_tile),
    .pe_levels      (pe_levels),
    .pe_done        (pe_done),
    .pe_rd_req      (pe_rd_req),
    .pe_rd_grant    (pe_rd_grant),
    .mem_rd_done    (mem_rd_done),
    .busy           (busy),
    .layer_done     (layer_done)
  );

  always #5 clk = ~clk;

  // PE model: pulses done DONE_DELAY cycles after each observed start.
  always @(negedge clk) begin
    logic [NUM_PE-1:0] d;
    int nc;
    d = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      nc = cnt[i];
      if (nc > 0) begin
        nc = nc - 1;
        if (nc == 0 && auto_en) d[i] = 1'b1;
      end
      if (pe_start[i] && auto_en) nc = DONE_DELAY;
      cnt[i] <= nc;
    end
    done_auto <= d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_xfer(input int tiles, input int levels);
    @(negedge clk);
    cfg_num_tiles  = tiles[TILE_W-1:0];
    cfg_num_levels = levels[LVL_W-1:0];
    cfg_valid      = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int found;
    start_exp_t e;
    logic [NUM_PE-1:0] ge;
    logic [NUM_PE-1:0] held;

    cfg_valid = 1'b0; cfg_num_tiles = '0; cfg_num_levels = '0;
    pe_rd_req = '0; mem_rd_done = 1'b0; done_man = '0; auto_en = 1'b0;
    for (int i = 0; i < NUM_PE; i++) cnt[i] = 0;

    // Reset state
    #3;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pe_start", pe_start, 0);
    check("rst_grant", pe_rd_grant, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_pe_levels", pe_levels, 0);
    @(negedge clk);
    rst = 1'b1;

    // Zero-tile layer
    cfg_xfer(0, 1);
    @(negedge clk);
    check("t3_busy", busy, 1);
    check("t3_layer_done", layer_done, 1);
    check("t3_cfg_ready_low", cfg_ready, 0);
    @(negedge clk);
    check("t3_busy_clr", busy, 0);
    check("t3_layer_done_clr", layer_done, 0);
    check("t3_cfg_ready", cfg_ready, 1);

    // Six tiles, PEs finishing DONE_DELAY cycles after start
    auto_en = 1'b1;
    start_sb.push_back('{4'b0001, 0, 0});
    start_sb.push_back('{4'b0010, 1, 1});
    start_sb.push_back('{4'b0100, 2, 2});
    start_sb.push_back('{4'b1000, 3, 3});
    start_sb.push_back('{4'b0001, 4, 11});
    start_sb.push_back('{4'b0010, 5, 12});
    cfg_xfer(6, 2);
    ndone = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("t2_pe_levels", pe_levels, 2);
      if (pe_start != '0) begin
        if (start_sb.size() == 0) begin
          check("t2_extra_start", pe_start, 0);
        end else begin
          e = start_sb.pop_front();
          check("t2_start_pe", pe_start, e.pe);
          check("t2_start_tile", pe_tile, e.tile);
          check("t2_start_cycle", cyc, e.cyc);
        end
      end
      if (layer_done) begin
        ndone++;
        check("t2_done_cycle", cyc, 24);
      end
    end
    check("t2_layer_done_count", ndone, 1);
    check("t2_missing_starts", start_sb.size(), 0);
    check("t2_idle_after", cfg_ready, 1);
    auto_en = 1'b0;

    // Spurious done ignored; PE restarted only the cycle after its done
    cfg_xfer(5, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_start_pe", pe_start, 32'(1) << k);
      check("t5_start_tile", pe_tile, k);
      if (k == 0) check("t5_levels_zero_as_one", pe_levels, 1);
    end
    @(negedge clk);
    check("t5_all_busy_no_start", pe_start, 0);
    done_man = 4'b0010;
    @(negedge clk);
    done_man = '0;
    check("t5_restart_pe1", pe_start, 4'b0010);
    check("t5_restart_tile", pe_tile, 4);
    @(negedge clk); done_man = 4'b0100;
    @(negedge clk); done_man = '0;
    @(negedge clk); done_man = 4'b0100;
    @(negedge clk); done_man = '0;
    @(negedge clk); done_man = 4'b1001;
    @(negedge clk); done_man = '0;
    repeat (4) begin
      @(negedge clk);
      check("t5_pe1_still_busy", layer_done, 0);
    end
    done_man = 4'b0010;
    @(negedge clk);
    done_man = '0;
    check("t5_drain_wait", layer_done, 0);
    @(negedge clk);
    check("t5_layer_done", layer_done, 1);
    @(negedge clk);
    check("t5_cfg_ready", cfg_ready, 1);

    // Read arbiter rotation with all requests held
    grant_sb.push_back(4'b0001);
    grant_sb.push_back(4'b0010);
    grant_sb.push_back(4'b0100);
    grant_sb.push_back(4'b1000);
    grant_sb.push_back(4'b0001);
    @(negedge clk);
    pe_rd_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      found = 0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        check("t4_onehot", ($countones(pe_rd_grant) <= 1) ? 1 : 0, 1);
        if (pe_rd_grant != '0) begin
          found = 1;
          break;
        end
      end
      check("t4_grant_seen", found, 1);
      ge = grant_sb.pop_front();
      check("t4_grant_order", pe_rd_grant, ge);
      held = pe_rd_grant;
      @(negedge clk);
      check("t4_grant_held", pe_rd_grant, held);
      mem_rd_done = 1'b1;
      @(negedge clk);
      mem_rd_done = 1'b0;
      check("t4_grant_released", pe_rd_grant, 0);
      if (k == 4) pe_rd_req = '0;
    end
    @(negedge clk);
    check("t4_no_req_no_grant", pe_rd_grant, 0);
    mem_rd_done = 1'b1;
    @(negedge clk);
    mem_rd_done = 1'b0;
    pe_rd_req = 4'b0101;
    @(negedge clk);
    check("t4_ptr_after_pe0", pe_rd_grant, 4'b0100);
    pe_rd_req = '0;
    @(negedge clk);
    check("t4_drop_releases", pe_rd_grant, 0);
    pe_rd_req = 4'b0101;
    @(negedge clk);
    check("t4_ptr_after_drop", pe_rd_grant, 4'b0001);
    pe_rd_req = '0;
    @(negedge clk);

    // Asynchronous reset mid-dispatch
    auto_en = 1'b1;
    cfg_xfer(8, 3);
    @(negedge clk);
    check("t1_start_pe0", pe_start, 4'b0001);
    pe_rd_req = 4'b0010;
    @(negedge clk);
    check("t1_start_pe1", pe_start, 4'b0010);
    @(negedge clk);
    check("t1_grant_before_rst", pe_rd_grant, 4'b0010);
    #2 rst = 1'b0;
    #1;
    check("t1_pe_start", pe_start, 0);
    check("t1_pe_tile", pe_tile, 0);
    check("t1_grant", pe_rd_grant, 0);
    check("t1_busy", busy, 0);
    check("t1_cfg_ready", cfg_ready, 1);
    check("t1_layer_done", layer_done, 0);
    check("t1_pe_levels", pe_levels, 0);
    pe_rd_req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (layer_done) ndone++;
    end
    check("t1_no_layer_done", ndone, 0);
    check("t1_idle_after", cfg_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
